// File: rtl/sdram_frame_writer.sv
`default_nettype none
//==============================================================================
// Module : sdram_frame_writer
// Avalon-MM burst write master draining a show-ahead pixel FIFO into the SDRAM
// frame buffer. Define SDRAM_FRAME_WRITER_DOUBLE_BUFFER_EN to ping-pong frames.
// Rev    : 1.0  initial release
//==============================================================================
module sdram_frame_writer #(
    parameter int          SDRAM_DATA_WIDTH = 64,
    parameter int          BURST_LEN        = 16,
    parameter logic [26:0] BASE_ADDR        = 27'h400_0000,
    parameter logic [31:0] FRAME_WORDS      = 32'hFD200,
    parameter int          USEDW_WIDTH      = 9
) (
    input  logic                          sdram_clk,
    input  logic                          rst,
    input  logic                          enable_i,
    input  logic [SDRAM_DATA_WIDTH-1:0]   src_q_i,
    input  logic [USEDW_WIDTH-1:0]        src_usedw_i,
    output logic                          src_rdreq_o,
    output logic [26:0]                   sdram_address_o,
    output logic [7:0]                    sdram_burstcount_o,
    output logic [SDRAM_DATA_WIDTH-1:0]   sdram_writedata_o,
    output logic [SDRAM_DATA_WIDTH/8-1:0] sdram_byteenable_o,
    output logic                          sdram_write_o,
    input  logic                          sdram_waitrequest_i,
    output logic                          frame_ready_o,
    output logic                          frame_done_o,
    output logic [15:0]                   frame_count_o,
    output logic                          last_buf_o
);

    localparam logic [31:0] c_BURST_LEN = 32'(BURST_LEN);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [26:0] r_address;
    logic [7:0]  r_burstcount;
    logic [7:0]  r_beats;
    logic [31:0] r_remaining;
    logic        r_frame_ready;
    logic        r_frame_done;
    logic [15:0] r_frame_count;
    logic [7:0]  w_blen;
    logic        w_start;
    logic        w_accept;
    logic        w_last_beat;
    logic        w_frame_end;

    assign w_blen      = (r_remaining < c_BURST_LEN) ? r_remaining[7:0] : c_BURST_LEN[7:0];
    assign w_start     = (r_state == S_IDLE) && enable_i &&
                         (32'(src_usedw_i) >= {24'd0, w_blen});
    assign w_accept    = (r_state == S_BURST) && !sdram_waitrequest_i;
    assign w_last_beat = w_accept && (r_beats == 8'd1);
    // The latched burst length equals blen for the burst in flight.
    assign w_frame_end = w_last_beat && (r_remaining == {24'd0, r_burstcount});

    always_ff @(posedge sdram_clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start)     w_state_next = S_BURST;
            S_BURST: if (w_last_beat) w_state_next = S_IDLE;
            default:                  w_state_next = S_IDLE;
        endcase
    end

`ifdef SDRAM_FRAME_WRITER_DOUBLE_BUFFER_EN
    localparam logic [26:0] c_BUF1_ADDR = BASE_ADDR + FRAME_WORDS[26:0];
    logic r_cur_buf;
    logic r_last_buf;
`endif

    always_ff @(posedge sdram_clk) begin
        if (rst) begin
            r_address     <= BASE_ADDR;
            r_burstcount  <= 8'd0;
            r_beats       <= 8'd0;
            r_remaining   <= FRAME_WORDS;
            r_frame_ready <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= 16'd0;
`ifdef SDRAM_FRAME_WRITER_DOUBLE_BUFFER_EN
            r_cur_buf     <= 1'b0;
            r_last_buf    <= 1'b0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            if (w_start) begin
                r_burstcount <= w_blen;
                r_beats      <= w_blen;
            end
            if (w_accept) r_beats <= r_beats - 8'd1;
            if (w_frame_end) begin
                r_frame_done  <= 1'b1;
                r_frame_ready <= 1'b1;
                r_frame_count <= r_frame_count + 16'd1;
                r_remaining   <= FRAME_WORDS;
`ifdef SDRAM_FRAME_WRITER_DOUBLE_BUFFER_EN
                r_address     <= r_cur_buf ? BASE_ADDR : c_BUF1_ADDR;
                r_last_buf    <= r_cur_buf;
                r_cur_buf     <= ~r_cur_buf;
`else
                r_address     <= BASE_ADDR;
`endif
            end else if (w_last_beat) begin
                r_address   <= r_address + {19'd0, r_burstcount};
                r_remaining <= r_remaining - {24'd0, r_burstcount};
            end
        end
    end

    assign src_rdreq_o        = w_accept;
    assign sdram_address_o    = r_address;
    assign sdram_burstcount_o = r_burstcount;
    assign sdram_writedata_o  = src_q_i;
    assign sdram_byteenable_o = '1;
    assign sdram_write_o      = (r_state == S_BURST);
    assign frame_ready_o      = r_frame_ready;
    assign frame_done_o       = r_frame_done;
    assign frame_count_o      = r_frame_count;
`ifdef SDRAM_FRAME_WRITER_DOUBLE_BUFFER_EN
    assign last_buf_o         = r_last_buf;
`else
    assign last_buf_o         = 1'b0;
`endif

endmodule
`default_nettype wire
